// File: rtl/spi_mstr.sv
// rtl/spi_mstr.sv - 16-bit mode-0 SPI master with five decoded active-low selects
// Optional: define SPI_MISO_SYNC_EN to pass MISO through a 2-flop synchronizer.
module spi_mstr #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_SPI,
    input  logic [15:0] SPI_data,
    input  logic [2:0]  ss,
    input  logic        MISO,
    output logic        SCLK,
    output logic        MOSI,
    output logic [4:0]  SS_n,
    output logic        SPI_done,
    output logic [15:0] rx_data
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_cnt;
    logic [15:0]   tx_shift;
    logic [15:0]   rx_shift;
    logic [2:0]    ss_reg;
    logic          miso_s;
    logic          sample_en;

    // Codes 5..7 shift the one-hot out of the low five bits, leaving every select deasserted.
    function automatic logic [4:0] ss_decode(input logic [2:0] code);
        logic [7:0] onehot;
        onehot = 8'b1 << code;
        return ~onehot[4:0];
    endfunction

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_ff <= 2'b00;
        end else begin
            miso_ff <= {miso_ff[0], MISO};
        end
    end

    assign miso_s    = miso_ff[1];
    // Two clocks into the high phase the synchronizer holds the value present at the rise.
    assign sample_en = (state == SHIFT) && SCLK && (cnt == CNT_ONE);
`else
    assign miso_s    = MISO;
    assign sample_en = ((state == FRONT) && (cnt == HALF_M1)) ||
                       ((state == SHIFT) && (cnt == FULL_M1) && (bit_cnt != 4'd0));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= 16'h0000;
        end else if (sample_en) begin
            rx_shift <= {rx_shift[14:0], miso_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= 4'd0;
            tx_shift <= 16'h0000;
            ss_reg   <= 3'd0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            SS_n     <= 5'h1f;
            SPI_done <= 1'b0;
            rx_data  <= 16'h0000;
        end else begin
            SPI_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wrt_SPI) begin
                        tx_shift <= SPI_data;
                        ss_reg   <= ss;
                        SS_n     <= ss_decode(ss);
                        MOSI     <= SPI_data[15];
                        cnt      <= '0;
                        bit_cnt  <= 4'd0;
                        state    <= FRONT;
                    end
                end
                FRONT: begin
                    SS_n <= ss_decode(ss_reg);
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        SCLK    <= 1'b1;
                        bit_cnt <= bit_cnt + 4'd1;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SHIFT: begin
                    SS_n <= ss_decode(ss_reg);
                    if (cnt == HALF_M1) begin
                        SCLK     <= 1'b0;
                        tx_shift <= {tx_shift[14:0], 1'b0};
                        MOSI     <= tx_shift[14];
                        cnt      <= cnt + CNT_ONE;
                    end else if (cnt == FULL_M1) begin
                        cnt <= '0;
                        // bit_cnt wraps to zero only after the 16th rise, so the last low phase is complete.
                        if (bit_cnt == 4'd0) begin
                            state <= BACK;
                        end else begin
                            SCLK    <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BACK: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        SS_n     <= 5'h1f;
                        SPI_done <= 1'b1;
                        rx_data  <= rx_shift;
                        MOSI     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mstr.sv
// tb/tb_spi_mstr.sv - directed and random transactions for spi_mstr against a word-level model
module tb_spi_mstr;

    localparam int DIV      = 32;
    localparam int DONE_CYC = 1 + 17 * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrt_SPI;
    logic [15:0] SPI_data;
    logic [2:0]  ss;
    logic        MISO;
    logic        SCLK;
    logic        MOSI;
    logic [4:0]  SS_n;
    logic        SPI_done;
    logic [15:0] rx_data;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_rx;

    always #5 clk = ~clk;

    spi_mstr #(.SCLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wrt_SPI  (wrt_SPI),
        .SPI_data (SPI_data),
        .ss       (ss),
        .MISO     (MISO),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
        .SPI_done (SPI_done),
        .rx_data  (rx_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge that is an idle cycle; returns at the negedge where SPI_done is seen.
    task automatic run_txn(input string name, input logic [15:0] data, input logic [2:0] code,
                           input logic [15:0] mword, input int busy_at, input int abort_at);
        logic [4:0]  exp_ssn;
        logic [4:0]  want_ssn;
        logic [15:0] mosi_cap;
        logic [15:0] rx_seen;
        logic        sclk_p;
        int          rises, idx, done_cnt, done_cyc, ssn_err, rx_err;
        exp_ssn  = (code < 3'd5) ? ~(5'b00001 << code) : 5'h1f;
        mosi_cap = 16'h0000;
        rx_seen  = 16'h0000;
        sclk_p   = 1'b0;
        rises    = 0;
        idx      = 14;
        done_cnt = 0;
        done_cyc = 0;
        ssn_err  = 0;
        rx_err   = 0;
        SPI_data = data;
        ss       = code;
        wrt_SPI  = 1'b1;
        MISO     = mword[15];
        for (int c = 1; c <= DONE_CYC + 20 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (c == 1 || c == busy_at + 1) begin
                wrt_SPI  = 1'b0;
                SPI_data = ~data;
                ss       = ~code;
            end
            if (c == busy_at) begin
                wrt_SPI  = 1'b1;
                SPI_data = 16'hffff;
                ss       = 3'd0;
            end
            if (c == abort_at) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk({name, " abort SCLK"}, 32'(SCLK), 32'(1'b0));
                chk({name, " abort SS_n"}, 32'(SS_n), 32'h1f);
                chk({name, " abort SPI_done"}, 32'(SPI_done), 32'(1'b0));
                rst_n = 1'b1;
                for (int k = 0; k < DONE_CYC; k++) begin
                    @(negedge clk);
                    if (SPI_done) done_cnt++;
                    if (SS_n !== 5'h1f) ssn_err++;
                end
                chk({name, " abort no done"}, 32'(done_cnt), 32'd0);
                chk({name, " abort SS_n idle"}, 32'(ssn_err), 32'd0);
                last_rx = 16'h0000;
                chk({name, " abort rx_data"}, 32'(rx_data), 32'(last_rx));
                return;
            end
            if (SCLK && !sclk_p) begin
                if (rises < 16) mosi_cap[15 - rises] = MOSI;
                rises++;
            end
            if (!SCLK && sclk_p && idx >= 0) begin
                MISO = mword[idx];
                idx--;
            end
            sclk_p   = SCLK;
            want_ssn = (c < DONE_CYC) ? exp_ssn : 5'h1f;
            if (SS_n !== want_ssn) ssn_err++;
            if (SPI_done) begin
                done_cnt++;
                done_cyc = c;
                rx_seen  = rx_data;
            end else if (rx_data !== last_rx) begin
                rx_err++;
            end
        end
        chk({name, " done cycle"}, 32'(done_cyc), 32'(DONE_CYC));
        chk({name, " done count"}, 32'(done_cnt), 32'd1);
        chk({name, " sclk rises"}, 32'(rises), 32'd16);
        chk({name, " mosi word"}, 32'(mosi_cap), 32'(data));
        chk({name, " SS_n errors"}, 32'(ssn_err), 32'd0);
        chk({name, " rx hold errors"}, 32'(rx_err), 32'd0);
        chk({name, " rx_data"}, 32'(rx_seen), 32'(mword));
        last_rx = mword;
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        wrt_SPI  = 1'b0;
        SPI_data = 16'h0000;
        ss       = 3'd0;
        MISO     = 1'b0;
        last_rx  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset SCLK", 32'(SCLK), 32'(1'b0));
        chk("reset MOSI", 32'(MOSI), 32'(1'b0));
        chk("reset SS_n", 32'(SS_n), 32'h1f);
        chk("reset SPI_done", 32'(SPI_done), 32'(1'b0));
        chk("reset rx_data", 32'(rx_data), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn("basic", 16'ha5c3, 3'b010, 16'($urandom), 0, 0);
        @(negedge clk);
        run_txn("eeprom", 16'($urandom), 3'b100, 16'h007e, 0, 0);
        chk("eeprom data byte", 32'(rx_data[7:0]), 32'h7e);
        @(negedge clk);

        run_txn("busy", 16'ha5c3, 3'b001, 16'($urandom), 100, 0);
        bad = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (SPI_done || SS_n !== 5'h1f) bad++;
        end
        chk("busy no second txn", 32'(bad), 32'd0);

        run_txn("b2b first", 16'($urandom), 3'b011, 16'($urandom), 0, 0);
        wrt_SPI  = 1'b1;
        SPI_data = 16'h1234;
        ss       = 3'b001;
        @(negedge clk);
        chk("b2b ignored SS_n", 32'(SS_n), 32'h1f);
        chk("b2b ignored done", 32'(SPI_done), 32'(1'b0));
        run_txn("b2b second", 16'($urandom), 3'b000, 16'($urandom), 0, 0);
        @(negedge clk);

        run_txn("abort", 16'($urandom), 3'b010, 16'($urandom), 0, 300);
        @(negedge clk);
        run_txn("after abort", 16'($urandom), 3'b000, 16'($urandom), 0, 0);
        @(negedge clk);

        run_txn("invalid ss", 16'($urandom), 3'b111, 16'($urandom), 0, 0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            run_txn("random", 16'($urandom), 3'($urandom_range(0, 4)), 16'($urandom), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
